// File: rtl/rst_sequencer.sv
// Pixel-clock reset manager: synchronised arst release, PLL lock qualification,
// staged active-low reset release and filtered lock-loss recovery.
module rst_sequencer #(
    parameter int NUM_RST         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int STEP_CYC        = 16,
    parameter int LOCK_LOSS_FILT  = 4
) (
    input  logic               clk_pix,
    input  logic               arst,
    input  logic               pll_lock,
    input  logic               sw_rst,
    input  logic               clr_sticky,
    output logic [NUM_RST-1:0] srst_n,
    output logic               rst_done,
    output logic               lock_lost,
    output logic [7:0]         lock_lost_cnt
);
    localparam int STB_W  = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam int LOSS_W = $clog2(LOCK_LOSS_FILT + 1);

    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_RST - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [LOSS_W-1:0]  LOSS_HIT  = LOSS_W'(LOCK_LOSS_FILT);
    localparam logic [NUM_RST-1:0] RST_ONE   = NUM_RST'(1);

    typedef enum logic [2:0] {WAIT_LOCK, STABLE, RELEASE, RUN, HOLD} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   rst_int;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;

    state_t              state_q, state_d;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic [NUM_RST-1:0]  srst_q, srst_d;
    logic                done_q, done_d;
    logic                lost_q, lost_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                filt_act, loss_evt, go_release, go_hold;

    // Assertion propagates immediately; release waits SYNC_STAGES edges.
    always_ff @(posedge clk_pix or posedge arst) begin
        if (arst) rst_sync <= '1;
        else      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
    end
    assign rst_int = rst_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_pix or posedge rst_int) begin
        if (rst_int) lock_sync <= '0;
        else         lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
    end
    assign lock_s = lock_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_pix or posedge rst_int) begin
        if (rst_int) begin
            state_q  <= WAIT_LOCK;
            stable_q <= '0;
            step_q   <= '0;
            idx_q    <= '0;
            loss_q   <= '0;
            srst_q   <= '0;
            done_q   <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            loss_q   <= loss_d;
            srst_q   <= srst_d;
            done_q   <= done_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stable_d   = stable_q;
        step_d     = step_q;
        idx_d      = idx_q;
        srst_d     = srst_q;
        done_d     = done_q;
        lost_d     = lost_q;
        cnt_d      = cnt_q;
        go_release = 1'b0;
        go_hold    = 1'b0;

        filt_act = (state_q == RELEASE) || (state_q == RUN) || (state_q == HOLD);
        loss_evt = filt_act && (loss_q == LOSS_HIT);
        loss_d   = (filt_act && !lock_s) ? loss_q + 1'b1 : '0;

        if (clr_sticky) begin
            lost_d = 1'b0;
            cnt_d  = '0;
        end

        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = STABLE;
                    stable_d = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    stable_d = '0;
                end else if (stable_q == STB_LAST) begin
                    go_release = 1'b1;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            RELEASE: begin
                if (sw_rst) begin
                    go_hold = 1'b1;
                end else if (step_q == STEP_LAST) begin
                    // srst_n is a thermometer code: shift in the next released bit.
                    step_d = '0;
                    srst_d = (srst_q << 1) | RST_ONE;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            RUN: begin
                if (sw_rst) go_hold = 1'b1;
            end
            HOLD: begin
                if (sw_rst)                 step_d     = '0;
                else if (step_q == STEP_LAST) go_release = 1'b1;
                else                        step_d     = step_q + 1'b1;
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (go_release) begin
            srst_d   = RST_ONE;
            step_d   = '0;
            stable_d = '0;
            idx_d    = IDX_ONE;
            if (NUM_RST == 1) begin
                done_d  = 1'b1;
                state_d = RUN;
            end else begin
                state_d = RELEASE;
            end
        end

        if (go_hold) begin
            state_d = HOLD;
            srst_d  = '0;
            done_d  = 1'b0;
            step_d  = '0;
        end

        // A filtered loss overrides everything, including a same-cycle sw_rst.
        if (loss_evt) begin
            state_d  = WAIT_LOCK;
            srst_d   = '0;
            done_d   = 1'b0;
            stable_d = '0;
            step_d   = '0;
            idx_d    = '0;
            loss_d   = '0;
            lost_d   = 1'b1;
            cnt_d    = sat_inc8(clr_sticky ? 8'd0 : cnt_q);
        end
    end

    assign srst_n        = srst_q;
    assign rst_done      = done_q;
    assign lock_lost     = lost_q;
    assign lock_lost_cnt = cnt_q;

endmodule
